// File: rtl/vend_txn_controller.sv
// Vending machine transaction sequencer: coin credit, selection checks, dispense
// handshake and greedy change payout. Every output comes straight from a register.
module vend_txn_controller #(
    parameter int PRICE0      = 15,
    parameter int PRICE1      = 20,
    parameter int PRICE2      = 25,
    parameter int PRICE3      = 30,
    parameter int PRICE4      = 35,
    parameter int CREDIT_MAX  = 100,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin,
    output logic       coin_accept,
    output logic       coin_reject,
    input  logic       sel_valid,
    input  logic [2:0] sel,
    input  logic       cancel,
    output logic       err_sel,
    output logic       disp_req,
    output logic [2:0] disp_item,
    input  logic       disp_done,
    output logic       chg_valid,
    output logic [1:0] chg_coin,
    input  logic       chg_ready,
    output logic [7:0] credit,
    output logic       busy
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

    state_t        state, state_nx;
    logic [7:0]    credit_nx;
    logic [2:0]    item_nx;
    logic [TW-1:0] tmo_cnt, tmo_nx;
    logic          acc_nx, rej_nx, err_nx;
    logic          req_nx, cv_nx, busy_nx;
    logic [1:0]    coin_nx;
    logic [8:0]    sum9;

    function automatic logic [7:0] coin_value(input logic [1:0] c);
        case (c)
            2'd0:    coin_value = 8'd5;
            2'd1:    coin_value = 8'd10;
            2'd2:    coin_value = 8'd20;
            default: coin_value = 8'd50;
        endcase
    endfunction

    function automatic logic [1:0] greedy_coin(input logic [7:0] amt);
        if (amt >= 8'd50)      greedy_coin = 2'd3;
        else if (amt >= 8'd20) greedy_coin = 2'd2;
        else if (amt >= 8'd10) greedy_coin = 2'd1;
        else                   greedy_coin = 2'd0;
    endfunction

    function automatic logic [7:0] item_price(input logic [2:0] s);
        case (s)
            3'd0:    item_price = 8'(PRICE0);
            3'd1:    item_price = 8'(PRICE1);
            3'd2:    item_price = 8'(PRICE2);
            3'd3:    item_price = 8'(PRICE3);
            default: item_price = 8'(PRICE4);
        endcase
    endfunction

    // 9-bit sum so the overflow check cannot be fooled by an 8-bit wrap
    assign sum9 = {1'b0, credit} + {1'b0, coin_value(coin)};

    always_comb begin
        state_nx  = state;
        credit_nx = credit;
        item_nx   = disp_item;
        tmo_nx    = tmo_cnt;
        acc_nx    = 1'b0;
        rej_nx    = 1'b0;
        err_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (coin_valid) begin
                    acc_nx    = 1'b1;
                    credit_nx = coin_value(coin);
                    tmo_nx    = '0;
                    state_nx  = COLLECT;
                end else if (sel_valid) begin
                    err_nx = 1'b1;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    rej_nx   = coin_valid;
                    state_nx = CHANGE;
                end else if (sel_valid) begin
                    rej_nx = coin_valid;
                    tmo_nx = '0;
                    if (sel <= 3'd4 && credit >= item_price(sel)) begin
                        credit_nx = credit - item_price(sel);
                        item_nx   = sel;
                        state_nx  = DISPENSE;
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (coin_valid && sum9 <= 9'(CREDIT_MAX)) begin
                    acc_nx    = 1'b1;
                    credit_nx = sum9[7:0];
                    tmo_nx    = '0;
                end else begin
                    // an overflow-rejected coin is not activity: the timeout keeps running
                    rej_nx = coin_valid;
                    if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) state_nx = CHANGE;
                    else                                 tmo_nx   = tmo_cnt + TW'(1);
                end
            end
            DISPENSE: begin
                rej_nx = coin_valid;
                if (disp_done) state_nx = (credit == 8'd0) ? IDLE : CHANGE;
            end
            CHANGE: begin
                rej_nx = coin_valid;
                if (chg_ready) begin
                    credit_nx = credit - coin_value(chg_coin);
                    if (credit_nx == 8'd0) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        req_nx  = (state_nx == DISPENSE);
        cv_nx   = (state_nx == CHANGE);
        coin_nx = cv_nx ? greedy_coin(credit_nx) : 2'd0;
        busy_nx = req_nx | cv_nx;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            credit      <= '0;
            disp_item   <= '0;
            tmo_cnt     <= '0;
            coin_accept <= 1'b0;
            coin_reject <= 1'b0;
            err_sel     <= 1'b0;
            disp_req    <= 1'b0;
            chg_valid   <= 1'b0;
            chg_coin    <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            credit      <= credit_nx;
            disp_item   <= item_nx;
            tmo_cnt     <= tmo_nx;
            coin_accept <= acc_nx;
            coin_reject <= rej_nx;
            err_sel     <= err_nx;
            disp_req    <= req_nx;
            chg_valid   <= cv_nx;
            chg_coin    <= coin_nx;
            busy        <= busy_nx;
        end
    end

endmodule

// File: tb/tb_vend_txn_controller.sv
// Bench for vend_txn_controller: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model (credit, change-coin queue).
module tb_vend_txn_controller;

    localparam int T = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       coin_valid, sel_valid, cancel, disp_done, chg_ready;
    logic [1:0] coin;
    logic [2:0] sel;
    logic       coin_accept, coin_reject, err_sel, disp_req, chg_valid, busy;
    logic [2:0] disp_item;
    logic [1:0] chg_coin;
    logic [7:0] credit;

    int n_cmp = 0;
    int n_err = 0;

    vend_txn_controller #(.TIMEOUT_CYC(T)) dut (
        .clock(clock), .reset(reset),
        .coin_valid(coin_valid), .coin(coin),
        .coin_accept(coin_accept), .coin_reject(coin_reject),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .err_sel(err_sel),
        .disp_req(disp_req), .disp_item(disp_item), .disp_done(disp_done),
        .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ready(chg_ready),
        .credit(credit), .busy(busy)
    );

    always #5 clock = ~clock;

    // Reference model: credit, pending dispense, and the full list of change coins
    int price[5] = '{15, 20, 25, 30, 35};
    int cval[4]  = '{5, 10, 20, 50};
    int m_credit, m_item, m_idle;
    bit m_collect, m_disp, m_acc, m_rej, m_err;
    int m_queue[$];

    function automatic int code_of(input int v);
        case (v)
            5:       return 0;
            10:      return 1;
            20:      return 2;
            default: return 3;
        endcase
    endfunction

    task automatic refund();
        int rem;
        int c;
        rem = m_credit;
        m_collect = 0;
        m_queue.delete();
        while (rem > 0) begin
            c = (rem >= 50) ? 50 : (rem >= 20) ? 20 : (rem >= 10) ? 10 : 5;
            m_queue.push_back(c);
            rem -= c;
        end
    endtask

    task automatic model_edge();
        int v;
        m_acc = 0; m_rej = 0; m_err = 0;
        if (!reset) begin
            m_collect = 0; m_disp = 0; m_queue.delete();
            m_credit = 0; m_item = 0; m_idle = 0;
            return;
        end
        v = cval[coin];
        if (m_disp) begin
            m_rej = coin_valid;
            if (disp_done) begin
                m_disp = 0;
                if (m_credit > 0) refund();
            end
        end else if (m_queue.size() > 0) begin
            m_rej = coin_valid;
            if (chg_ready) m_credit -= m_queue.pop_front();
        end else if (m_collect) begin
            if (cancel) begin
                m_rej = coin_valid;
                refund();
            end else if (sel_valid) begin
                m_rej = coin_valid;
                m_idle = 0;
                if (sel <= 4 && m_credit >= price[sel]) begin
                    m_credit -= price[sel];
                    m_item = sel;
                    m_collect = 0;
                    m_disp = 1;
                end else m_err = 1;
            end else if (coin_valid && m_credit + v <= 100) begin
                m_acc = 1;
                m_credit += v;
                m_idle = 0;
            end else begin
                m_rej = coin_valid;
                if (m_idle == T - 1) refund();
                else m_idle++;
            end
        end else begin
            if (coin_valid) begin
                m_acc = 1; m_credit = v; m_collect = 1; m_idle = 0;
            end else if (sel_valid) m_err = 1;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit paying;
        paying = (m_queue.size() > 0);
        check_val("credit", 32'(credit), 32'(m_credit));
        check_val("coin_accept", 32'(coin_accept), 32'(m_acc));
        check_val("coin_reject", 32'(coin_reject), 32'(m_rej));
        check_val("err_sel", 32'(err_sel), 32'(m_err));
        check_val("disp_req", 32'(disp_req), 32'(m_disp));
        check_val("disp_item", 32'(disp_item), 32'(m_item));
        check_val("chg_valid", 32'(chg_valid), 32'(paying));
        check_val("chg_coin", 32'(chg_coin), paying ? 32'(code_of(m_queue[0])) : 32'd0);
        check_val("busy", 32'(busy), 32'(m_disp || paying));
    endtask

    task automatic drive(input bit cv, input int cc, input bit sv, input int s,
                         input bit cn, input bit dd, input bit cr, input bit rs);
        reset = rs; coin_valid = cv; coin = 2'(cc); sel_valid = sv; sel = 3'(s);
        cancel = cn; disp_done = dd; chg_ready = cr;
        @(posedge clock);
        #1;
        model_edge();
        compare_all();
        reset = 1'b1; coin_valid = 1'b0; coin = 2'd0; sel_valid = 1'b0; sel = 3'd0;
        cancel = 1'b0; disp_done = 1'b0; chg_ready = 1'b0;
    endtask

    task automatic idle_cyc(); drive(0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic put_coin(input int cc); drive(1, cc, 0, 0, 0, 0, 0, 1); endtask
    task automatic pick(input int s); drive(0, 0, 1, s, 0, 0, 0, 1); endtask

    task automatic settle();
        int i;
        for (i = 0; i < 100 && (busy || chg_valid); i++) drive(0, 0, 0, 0, 0, 1, 1, 1);
        check_val("settle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0; coin_valid = 1'b0; coin = 2'd0; sel_valid = 1'b0; sel = 3'd0;
        cancel = 1'b0; disp_done = 1'b0; chg_ready = 1'b0;

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 3, 1, 2, 1, 1, 1, 0);
        check_val("rst_credit", 32'(credit), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);

        // exact payment
        put_coin(0);
        put_coin(1);
        check_val("exact_credit", 32'(credit), 32'd15);
        pick(0);
        check_val("exact_req", 32'(disp_req), 32'd1);
        check_val("exact_item", 32'(disp_item), 32'd0);
        idle_cyc();
        idle_cyc();
        check_val("exact_req_hold", 32'(disp_req), 32'd1);
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        check_val("exact_done_credit", 32'(credit), 32'd0);
        check_val("exact_no_chg", 32'(chg_valid), 32'd0);
        drive(0, 0, 0, 0, 0, 1, 0, 1);

        // change 50 - 25
        put_coin(3);
        pick(2);
        check_val("chg_credit", 32'(credit), 32'd25);
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        check_val("chg_first", 32'(chg_coin), 32'd2);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        check_val("chg_second", 32'(chg_coin), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        check_val("chg_done", 32'(chg_valid), 32'd0);

        // insufficient credit, cancel, invalid item
        put_coin(2);
        pick(4);
        check_val("insuf_err", 32'(err_sel), 32'd1);
        check_val("insuf_credit", 32'(credit), 32'd20);
        pick(6);
        check_val("bad_sel_err", 32'(err_sel), 32'd1);
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        check_val("cancel_coin", 32'(chg_coin), 32'd2);
        settle();
        pick(6);
        check_val("idle_sel_err", 32'(err_sel), 32'd1);

        // overflow and cancel with concurrent coin
        put_coin(3);
        put_coin(3);
        put_coin(0);
        check_val("ovf_reject", 32'(coin_reject), 32'd1);
        check_val("ovf_credit", 32'(credit), 32'd100);
        drive(1, 1, 0, 0, 1, 0, 0, 1);
        check_val("cancel_rej", 32'(coin_reject), 32'd1);
        check_val("cancel_50", 32'(chg_coin), 32'd3);
        settle();

        // timeout and backpressure
        put_coin(1);
        n = 0;
        while (!chg_valid && n < T + 5) begin
            idle_cyc();
            n++;
        end
        check_val("timeout_cycles", 32'(n), 32'(T));
        for (int i = 0; i < 5; i++) idle_cyc();
        check_val("bp_coin", 32'(chg_coin), 32'd1);
        check_val("bp_credit", 32'(credit), 32'd10);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        check_val("bp_done", 32'(credit), 32'd0);

        // reset in the middle of change payout
        put_coin(2);
        put_coin(1);
        put_coin(0);
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        check_val("mid_chg_credit", 32'(credit), 32'd35);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("mid_rst_credit", 32'(credit), 32'd0);
        check_val("mid_rst_valid", 32'(chg_valid), 32'd0);
        put_coin(0);
        check_val("post_rst_acc", 32'(coin_accept), 32'd1);
        check_val("post_rst_credit", 32'(credit), 32'd5);
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        settle();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom % 4) == 0, $urandom_range(0, 3),
                  ($urandom % 8) == 0, $urandom_range(0, 7),
                  ($urandom % 30) == 0, ($urandom % 3) == 0,
                  ($urandom % 2) == 0, ($urandom % 500) != 0);
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
